// File: rtl/rv32i_core_pkg.sv
// Shared definitions for the multicycle RV32I core: fetch FSM encoding and
// fetch-related constants.
package rv32I_core_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2,
    FETCH_HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTRUCTION      = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_INCREMENT         = 32'd4;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/rv32i_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// holds the returned word (or a fault entry) until decode takes it.
module rv32i_fetch_unit
  import rv32I_core_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  output logic                         o_imem_req_valid,
  output logic [WORD_SIZE-1:0]         o_imem_req_addr,
  input  logic                         i_imem_req_ready,
  input  logic                         i_imem_rsp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] i_imem_rsp_data,
  input  logic                         i_imem_rsp_error,
  output logic                         o_fetch_valid,
  output logic [INSTRUCTION_WIDTH-1:0] o_fetch_instruction,
  output logic [WORD_SIZE-1:0]         o_fetch_pc,
  output logic                         o_fetch_fault,
  input  logic                         i_decode_ready,
  input  logic                         i_redirect_valid,
  input  logic [WORD_SIZE-1:0]         i_redirect_pc,
  output fetch_state_t                 o_debug_state
);

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_WORD = INSTRUCTION_WIDTH'(NOP_INSTRUCTION);
  localparam logic [WORD_SIZE-1:0]         PC_STEP  = WORD_SIZE'(PC_INCREMENT);

  fetch_state_t                 state_q, state_d;
  logic [WORD_SIZE-1:0]         pc_q, pc_d;
  logic                         hold_valid_q, hold_valid_d;
  logic                         hold_fault_q, hold_fault_d;
  logic [INSTRUCTION_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [WORD_SIZE-1:0]         hold_pc_q, hold_pc_d;
  logic                         pc_misaligned;
  logic                         redirect_misaligned;

  assign pc_misaligned       = is_misaligned(pc_q[1:0]);
  assign redirect_misaligned = is_misaligned(i_redirect_pc[1:0]);

  // Handshakes: a request transfers on a cycle with o_imem_req_valid and
  // i_imem_req_ready both high; a response is taken whenever i_imem_rsp_valid
  // is high (no backpressure); the held entry transfers on o_fetch_valid and
  // i_decode_ready both high. A redirect gates the request in the same cycle.
  assign o_imem_req_valid = (state_q == FETCH_REQ) && !i_redirect_valid &&
                            !pc_misaligned && !i_rst;
  assign o_imem_req_addr  = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_valid_d = hold_valid_q;
    hold_fault_d = hold_fault_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    case (state_q)
      FETCH_REQ: begin
        if (i_redirect_valid) begin
          pc_d = i_redirect_pc;
          if (redirect_misaligned) begin
            state_d      = FETCH_HOLD;
            hold_valid_d = 1'b1;
            hold_fault_d = 1'b1;
            hold_instr_d = NOP_WORD;
            hold_pc_d    = i_redirect_pc;
          end
        end else if (pc_misaligned) begin
          // A misaligned target that arrived outside FETCH_REQ faults here.
          state_d      = FETCH_HOLD;
          hold_valid_d = 1'b1;
          hold_fault_d = 1'b1;
          hold_instr_d = NOP_WORD;
          hold_pc_d    = pc_q;
        end else if (i_imem_req_ready) begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (i_redirect_valid) begin
          pc_d    = i_redirect_pc;
          state_d = i_imem_rsp_valid ? FETCH_REQ : FETCH_DRAIN;
        end else if (i_imem_rsp_valid) begin
          state_d      = FETCH_HOLD;
          hold_valid_d = 1'b1;
          hold_fault_d = i_imem_rsp_error;
          hold_instr_d = i_imem_rsp_error ? NOP_WORD : i_imem_rsp_data;
          hold_pc_d    = pc_q;
        end
      end
      FETCH_DRAIN: begin
        if (i_redirect_valid) pc_d = i_redirect_pc;
        if (i_imem_rsp_valid) state_d = FETCH_REQ;
      end
      FETCH_HOLD: begin
        if (i_redirect_valid || i_decode_ready) begin
          pc_d         = i_redirect_valid ? i_redirect_pc : pc_q + PC_STEP;
          state_d      = FETCH_REQ;
          hold_valid_d = 1'b0;
          hold_fault_d = 1'b0;
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= FETCH_REQ;
      pc_q         <= RESET_VECTOR;
      hold_valid_q <= 1'b0;
      hold_fault_q <= 1'b0;
      hold_instr_q <= NOP_WORD;
      hold_pc_q    <= RESET_VECTOR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_valid_q <= hold_valid_d;
      hold_fault_q <= hold_fault_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign o_fetch_valid       = hold_valid_q;
  assign o_fetch_fault       = hold_fault_q;
  assign o_fetch_instruction = hold_instr_q;
  assign o_fetch_pc          = hold_pc_q;
  assign o_debug_state       = state_q;

endmodule
